// File: rtl/msrv32_pkg.sv
// Shared constants and types for the instruction-memory responder.
// Imported by the responder top level and reused by the testbench.
package msrv32_pkg;

    localparam logic [31:0] MSRV32_NOP = 32'h0000_0013;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        DATA,
        ERR1,
        ERR2
    } imem_state_t;

    // The range check is an unsigned compare on the base-relative offset, so an
    // address below the base wraps high and is rejected as well.
    function automatic logic fetchIsBad(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] rangeBytes);
        logic [31:0] offset;
        offset = addr - base;
        return (addr[1:0] != 2'b00) || (offset >= rangeBytes);
    endfunction

endpackage

// File: rtl/msrv32_imem_responder_if.sv
// Fetch bus between the PC stage (master) and the instruction responder (slave).
// Carries the AHB-lite-style address phase and the HREADY/HRESP data phase.
interface msrv32_imem_responder_if;

    logic [31:0] iaddr_in;
    logic        req_in;
    logic [31:0] instr_out;
    logic        ready_out;
    logic        error_out;

    modport master (
        output iaddr_in,
        output req_in,
        input  instr_out,
        input  ready_out,
        input  error_out
    );

    modport slave (
        input  iaddr_in,
        input  req_in,
        output instr_out,
        output ready_out,
        output error_out
    );

endinterface

// File: rtl/msrv32_imem_responder_array.sv
// Instruction word store: one write port for the loader, one registered read
// port for fetches. Read-first when both ports touch the same word.
module msrv32_imem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_in,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [31:0]   wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [31:0]   rd_data_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdData_q;

    // Both updates are non-blocking, so a same-edge read sees the old word.
    always_ff @(posedge clk_in) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rdData_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rdData_q;

endmodule

// File: rtl/msrv32_imem_responder.sv
// Instruction-bus responder: accepts fetch addresses, inserts programmable wait
// states, returns words from the on-chip array, and flags bad fetches with a two-cycle error.
module msrv32_imem_responder
    import msrv32_pkg::*;
#(
    parameter  int          DEPTH_WORDS = 1024,
    parameter  int          WAIT_STATES = 1,
    parameter  logic [31:0] BASE_ADDR   = 32'h0000_0000,
    localparam int          AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    msrv32_imem_responder_if.slave         bus,
    input  logic                           load_en_in,
    input  logic [AW-1:0]                  load_addr_in,
    input  logic [31:0]                    load_data_in
);

    localparam logic [31:0] RANGE_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_LOAD   = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    imem_state_t   state_q, state_d;
    logic [3:0]    waitCnt_q, waitCnt_d;
    logic [AW-1:0] wordIdx_q, wordIdx_d;
    logic          nopSel_q, nopSel_d;

    logic [31:0]   offsetIn;
    logic          readyInt;
    logic          accept;
    logic          badAddr;
    logic          rdEn;
    logic [AW-1:0] rdAddr;
    logic [31:0]   ramData;

    assign offsetIn = bus.iaddr_in - BASE_ADDR;
    assign badAddr  = fetchIsBad(bus.iaddr_in, BASE_ADDR, RANGE_BYTES);
    assign readyInt = (state_q == IDLE) || (state_q == DATA) || (state_q == ERR2);
    assign accept   = bus.req_in && readyInt;

    // The read is launched one cycle ahead of DATA: straight from the bus when
    // there are no wait states, otherwise from the captured index in the last WAIT cycle.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        wordIdx_d = wordIdx_q;
        nopSel_d  = nopSel_q;
        rdEn      = 1'b0;
        rdAddr    = wordIdx_q;

        case (state_q)
            WAIT: begin
                if (waitCnt_q == 4'd0) begin
                    state_d  = DATA;
                    nopSel_d = 1'b0;
                    rdEn     = 1'b1;
                end else begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end
            end

            ERR1: begin
                state_d  = ERR2;
                nopSel_d = 1'b1;
            end

            default: begin
                if (accept) begin
                    wordIdx_d = offsetIn[AW+1:2];
                    if (badAddr) begin
                        state_d = ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d   = WAIT;
                        waitCnt_d = WAIT_LOAD;
                    end else begin
                        state_d  = DATA;
                        nopSel_d = 1'b0;
                        rdEn     = 1'b1;
                        rdAddr   = offsetIn[AW+1:2];
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            waitCnt_q <= 4'd0;
            wordIdx_q <= '0;
            nopSel_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            wordIdx_q <= wordIdx_d;
            nopSel_q  <= nopSel_d;
        end
    end

    msrv32_imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk_in    (clk_in),
        .wr_en_i   (load_en_in),
        .wr_addr_i (load_addr_in),
        .wr_data_i (load_data_in),
        .rd_en_i   (rdEn),
        .rd_addr_i (rdAddr),
        .rd_data_o (ramData)
    );

    // The array output only moves on a read, so it already holds across IDLE/WAIT/ERR1.
    assign bus.instr_out = nopSel_q ? MSRV32_NOP : ramData;
    assign bus.ready_out = readyInt;
    assign bus.error_out = ((state_q == ERR1) || (state_q == ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_msrv32_imem_responder.sv
// Directed bench for the instruction responder: one instance with no wait
// states and one with two, sharing clock, reset and the loader port.
module tb_msrv32_imem_responder;
    import msrv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        loadEn;
    logic [9:0]  loadAddr;
    logic [31:0] loadData;

    int checkCount = 0;
    int errorCount = 0;

    msrv32_imem_responder_if busA ();
    msrv32_imem_responder_if busB ();

    always #5 clk = ~clk;

    msrv32_imem_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_STATES (0),
        .BASE_ADDR   (32'h0000_0000)
    ) dutA (
        .clk_in       (clk),
        .rst_in       (rst),
        .bus          (busA),
        .load_en_in   (loadEn),
        .load_addr_in (loadAddr),
        .load_data_in (loadData)
    );

    msrv32_imem_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_STATES (2),
        .BASE_ADDR   (32'h0000_0000)
    ) dutB (
        .clk_in       (clk),
        .rst_in       (rst),
        .bus          (busB),
        .load_en_in   (loadEn),
        .load_addr_in (loadAddr),
        .load_data_in (loadData)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic checkResp(input string tag, input int sel, input logic rdy, input logic err,
                             input logic [31:0] instr);
        if (sel == 0) begin
            checkOutput($sformatf("%s.ready", tag), 32'(busA.ready_out), 32'(rdy));
            checkOutput($sformatf("%s.error", tag), 32'(busA.error_out), 32'(err));
            checkOutput($sformatf("%s.instr", tag), busA.instr_out, instr);
        end else begin
            checkOutput($sformatf("%s.ready", tag), 32'(busB.ready_out), 32'(rdy));
            checkOutput($sformatf("%s.error", tag), 32'(busB.error_out), 32'(err));
            checkOutput($sformatf("%s.instr", tag), busB.instr_out, instr);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic req, input logic [31:0] addr);
        if (sel == 0) begin
            busA.req_in   = req;
            busA.iaddr_in = addr;
        end else begin
            busB.req_in   = req;
            busB.iaddr_in = addr;
        end
    endtask

    task automatic loadWord(input logic [9:0] idx, input logic [31:0] data);
        loadEn   = 1'b1;
        loadAddr = idx;
        loadData = data;
        @(negedge clk);
        loadEn   = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        loadEn   = 1'b0;
        loadAddr = '0;
        loadData = '0;
        applyStimulus(0, 1'b0, 32'h0);
        applyStimulus(1, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checkResp("rstA", 0, 1'b1, 1'b0, MSRV32_NOP);
        checkResp("rstB", 1, 1'b1, 1'b0, MSRV32_NOP);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            loadWord(10'(i), 32'hA0 + 32'(i));
        end
        loadWord(10'd1023, 32'h0000_C3FF);

        // Back-to-back fetches with no wait states: one word per cycle.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1'b1, 32'(i * 4));
            @(negedge clk);
            checkResp($sformatf("t1_%0d", i), 0, 1'b1, 1'b0, 32'hA0 + 32'(i));
        end
        applyStimulus(0, 1'b0, 32'h0);
        @(negedge clk);
        checkResp("t1_idle", 0, 1'b1, 1'b0, 32'hA3);

        // Two wait states; the request changes during WAIT and must be ignored.
        applyStimulus(1, 1'b1, 32'h4);
        @(negedge clk);
        checkResp("t2_wait1", 1, 1'b0, 1'b0, MSRV32_NOP);
        applyStimulus(1, 1'b1, 32'h8);
        @(negedge clk);
        checkResp("t2_wait2", 1, 1'b0, 1'b0, MSRV32_NOP);
        applyStimulus(1, 1'b0, 32'h0);
        @(negedge clk);
        checkResp("t2_data", 1, 1'b1, 1'b0, 32'hA1);
        @(negedge clk);
        checkResp("t2_idle", 1, 1'b1, 1'b0, 32'hA1);

        // Misaligned fetch, then a good request offered in ERR2.
        applyStimulus(0, 1'b1, 32'h6);
        @(negedge clk);
        checkResp("t3_err1", 0, 1'b0, 1'b1, 32'hA3);
        applyStimulus(0, 1'b1, 32'h8);
        @(negedge clk);
        checkResp("t3_err2", 0, 1'b1, 1'b1, MSRV32_NOP);
        @(negedge clk);
        checkResp("t3_data", 0, 1'b1, 1'b0, 32'hA2);
        applyStimulus(0, 1'b0, 32'h0);
        @(negedge clk);
        checkResp("t3_idle", 0, 1'b1, 1'b0, 32'hA2);

        // Range boundary: one past the end errors, the last word is fine, wrap errors.
        applyStimulus(0, 1'b1, 32'h0000_1000);
        @(negedge clk);
        checkResp("t4_oor_err1", 0, 1'b0, 1'b1, 32'hA2);
        applyStimulus(0, 1'b0, 32'h0);
        @(negedge clk);
        checkResp("t4_oor_err2", 0, 1'b1, 1'b1, MSRV32_NOP);
        @(negedge clk);
        checkResp("t4_oor_idle", 0, 1'b1, 1'b0, MSRV32_NOP);
        applyStimulus(0, 1'b1, 32'h0000_0FFC);
        @(negedge clk);
        checkResp("t4_last", 0, 1'b1, 1'b0, 32'h0000_C3FF);
        applyStimulus(0, 1'b1, 32'hFFFF_FFFC);
        @(negedge clk);
        checkResp("t4_wrap_err1", 0, 1'b0, 1'b1, 32'h0000_C3FF);
        applyStimulus(0, 1'b0, 32'h0);
        @(negedge clk);
        checkResp("t4_wrap_err2", 0, 1'b1, 1'b1, MSRV32_NOP);
        @(negedge clk);

        // Loader write to word 1 on the same edge its read is launched.
        applyStimulus(0, 1'b1, 32'h4);
        loadEn   = 1'b1;
        loadAddr = 10'd1;
        loadData = 32'h0000_BEEF;
        @(negedge clk);
        loadEn = 1'b0;
        checkResp("t5_old", 0, 1'b1, 1'b0, 32'hA1);
        @(negedge clk);
        checkResp("t5_new", 0, 1'b1, 1'b0, 32'h0000_BEEF);
        applyStimulus(0, 1'b0, 32'h0);
        @(negedge clk);

        // Reset in the middle of a waited fetch drops it completely.
        applyStimulus(1, 1'b1, 32'h8);
        @(negedge clk);
        checkResp("t6_wait", 1, 1'b0, 1'b0, 32'hA1);
        rst = 1'b1;
        applyStimulus(1, 1'b0, 32'h0);
        @(negedge clk);
        checkResp("t6_rst", 1, 1'b1, 1'b0, MSRV32_NOP);
        rst = 1'b0;
        @(negedge clk);
        checkResp("t6_after1", 1, 1'b1, 1'b0, MSRV32_NOP);
        @(negedge clk);
        checkResp("t6_after2", 1, 1'b1, 1'b0, MSRV32_NOP);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
